st_pattern_gen: RTL and testbench

ST_PATTERN_GEN -- requirements
Module: st_pattern_gen

---
 rtl/st_pattern_gen.sv | 166 ++++++++++++++++
 tb/tb_st_pattern_gen.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/st_pattern_gen.sv
// Avalon-ST video test-pattern source (bars, gradient, checker, moving ramp), one registered output stage.
// First pixel two edges after enable; stalls in place while src_ready=0, mode/enable honoured only at frame start.
module st_pattern_gen #(
   parameter int H_ACTIVE = 640,
   parameter int V_ACTIVE = 480
) (
   input  logic        clk_clk,
   input  logic        reset_reset_n,
   input  logic        enable,
   input  logic [1:0]  mode,
   output logic [23:0] src_data,
   output logic        src_valid,
   input  logic        src_ready,
   output logic        src_sof,
   output logic        src_eof,
   output logic [7:0]  frame_cnt
);

   localparam logic [0:0]  IDLE     = 1'b0;
   localparam logic [0:0]  RUN      = 1'b1;
   localparam logic [10:0] X_LAST   = 11'(H_ACTIVE - 1);
   localparam logic [10:0] Y_LAST   = 11'(V_ACTIVE - 1);
   localparam logic [10:0] BAR_LAST = 11'(H_ACTIVE / 8 - 1);

   logic [0:0]  state_q, state_d;
   logic [1:0]  mode_q, mode_d;
   logic [10:0] x_q, x_d;
   logic [10:0] y_q, y_d;
   logic [10:0] bar_cnt_q, bar_cnt_d;
   logic [2:0]  bar_q, bar_d;
   logic [7:0]  frame_cnt_q, frame_cnt_d;
   logic [23:0] data_q, data_d;
   logic        valid_q, valid_d;
   logic        sof_q, sof_d;
   logic        eof_q, eof_d;

   logic        load;
   logic        x_end;
   logic        last_px;
   logic [23:0] pix;

   assign load    = !valid_q || src_ready;
   assign x_end   = (x_q == X_LAST);
   assign last_px = x_end && (y_q == Y_LAST);

   // Pixel colour for the current (x,y); bar_q tracks x/(H_ACTIVE/8) without a divider.
   always_comb begin
      pix = '0;
      case (mode_q)
         2'd0: begin
            case (bar_q)
               3'd0:    pix = 24'hFFFFFF;
               3'd1:    pix = 24'hFFFF00;
               3'd2:    pix = 24'h00FFFF;
               3'd3:    pix = 24'h00FF00;
               3'd4:    pix = 24'hFF00FF;
               3'd5:    pix = 24'hFF0000;
               3'd6:    pix = 24'h0000FF;
               default: pix = 24'h000000;
            endcase
         end
         2'd1:    pix = {x_q[7:0], x_q[7:0], x_q[7:0]};
         2'd2:    pix = (x_q[5] ^ y_q[5]) ? 24'h000000 : 24'hFFFFFF;
         default: pix = {x_q[7:0] + frame_cnt_q, y_q[7:0], frame_cnt_q};
      endcase
   end

   always_comb begin
      state_d     = state_q;
      mode_d      = mode_q;
      x_d         = x_q;
      y_d         = y_q;
      bar_cnt_d   = bar_cnt_q;
      bar_d       = bar_q;
      frame_cnt_d = frame_cnt_q;
      data_d      = data_q;
      valid_d     = valid_q;
      sof_d       = sof_q;
      eof_d       = eof_q;

      if (load) begin
         valid_d = 1'b0;
         sof_d   = 1'b0;
         eof_d   = 1'b0;
      end

      case (state_q)
         IDLE: begin
            x_d       = '0;
            y_d       = '0;
            bar_cnt_d = '0;
            bar_d     = '0;
            if (enable) begin
               mode_d  = mode;
               state_d = RUN;
            end
         end
         default: begin
            if (load) begin
               valid_d = 1'b1;
               data_d  = pix;
               sof_d   = (x_q == 11'd0) && (y_q == 11'd0);
               eof_d   = last_px;
               if (x_end) begin
                  x_d       = '0;
                  bar_cnt_d = '0;
                  bar_d     = '0;
                  y_d       = last_px ? 11'd0 : y_q + 11'd1;
               end else begin
                  x_d = x_q + 11'd1;
                  if (bar_cnt_q == BAR_LAST) begin
                     bar_cnt_d = '0;
                     bar_d     = bar_q + 3'd1;
                  end else begin
                     bar_cnt_d = bar_cnt_q + 11'd1;
                  end
               end
               // Frame boundary: the only point where enable and mode are honoured.
               if (last_px) begin
                  frame_cnt_d = frame_cnt_q + 8'd1;
                  if (enable) begin
                     mode_d = mode;
                  end else begin
                     state_d = IDLE;
                  end
               end
            end
         end
      endcase
   end

   always_ff @(posedge clk_clk or negedge reset_reset_n) begin
      if (!reset_reset_n) begin
         state_q     <= IDLE;
         mode_q      <= '0;
         x_q         <= '0;
         y_q         <= '0;
         bar_cnt_q   <= '0;
         bar_q       <= '0;
         frame_cnt_q <= '0;
         data_q      <= '0;
         valid_q     <= 1'b0;
         sof_q       <= 1'b0;
         eof_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         mode_q      <= mode_d;
         x_q         <= x_d;
         y_q         <= y_d;
         bar_cnt_q   <= bar_cnt_d;
         bar_q       <= bar_d;
         frame_cnt_q <= frame_cnt_d;
         data_q      <= data_d;
         valid_q     <= valid_d;
         sof_q       <= sof_d;
         eof_q       <= eof_d;
      end
   end

   assign src_data  = data_q;
   assign src_valid = valid_q;
   assign src_sof   = sof_q;
   assign src_eof   = eof_q;
   assign frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_st_pattern_gen.sv
// Scoreboard bench: a 64x40 generator checked pixel-by-pixel, plus an 8x1 generator for frame counter wrap.
module tb_st_pattern_gen;

   localparam int H  = 64;
   localparam int V  = 40;
   localparam int HB = 8;
   localparam int VB = 1;

   logic        clk;
   logic        rst_n, en, rdy;
   logic [1:0]  md;
   logic [23:0] dat;
   logic        vld, sof, eof;
   logic [7:0]  fcnt;

   logic        rst_b_n, en_b, rdy_b;
   logic [1:0]  md_b;
   logic [23:0] dat_b;
   logic        vld_b, sof_b, eof_b;
   logic [7:0]  fcnt_b;

   st_pattern_gen #(.H_ACTIVE(H), .V_ACTIVE(V)) dut (
      .clk_clk(clk), .reset_reset_n(rst_n), .enable(en), .mode(md),
      .src_data(dat), .src_valid(vld), .src_ready(rdy),
      .src_sof(sof), .src_eof(eof), .frame_cnt(fcnt)
   );

   st_pattern_gen #(.H_ACTIVE(HB), .V_ACTIVE(VB)) dut_b (
      .clk_clk(clk), .reset_reset_n(rst_b_n), .enable(en_b), .mode(md_b),
      .src_data(dat_b), .src_valid(vld_b), .src_ready(rdy_b),
      .src_sof(sof_b), .src_eof(eof_b), .frame_cnt(fcnt_b)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int          n_chk = 0;
   int          n_pass = 0;
   logic [25:0] exp_q[$];
   logic [23:0] p105[$];
   logic [23:0] cap[V][H];
   int          mx = 0, my = 0, sof_cnt = 0, xfer_cnt = 0;
   logic [7:0]  fexp;
   bit          rnd = 1'b0;
   logic        rdy_fix = 1'b1;
   bit          b_done = 1'b0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", tag, got, exp);
   endtask

   function automatic logic [25:0] exp_pix(input int m, input int x, input int y, input logic [7:0] f);
      logic [23:0] bars[8];
      logic [23:0] d;
      logic [7:0]  xb, yb;
      logic        s, e;
      bars = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
               24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};
      xb = 8'(x);
      yb = 8'(y);
      case (m)
         0:       d = bars[x / (H / 8)];
         1:       d = {xb, xb, xb};
         2:       d = (((x >> 5) ^ (y >> 5)) & 1) != 0 ? 24'h000000 : 24'hFFFFFF;
         default: d = {8'(xb + f), yb, f};
      endcase
      s = (x == 0) && (y == 0);
      e = (x == H - 1) && (y == V - 1);
      return {s, e, d};
   endfunction

   task automatic push_frames(input int m, input int n);
      for (int k = 0; k < n; k++) begin
         for (int y = 0; y < V; y++)
            for (int x = 0; x < H; x++)
               exp_q.push_back(exp_pix(m, x, y, fexp));
         fexp = fexp + 8'd1;
      end
   endtask

   task automatic wait_sofs(input int n);
      int t = 0;
      while (sof_cnt < n && t < 30000) begin
         @(negedge clk); #1; t++;
      end
      chk("sof_wait", 32'(sof_cnt >= n), 32'd1);
   endtask

   task automatic wait_drain();
      int t = 0;
      while ((exp_q.size() != 0 || vld) && t < 30000) begin
         @(negedge clk); #1; t++;
      end
      chk("drain_q", 32'(exp_q.size()), 32'd0);
      chk("drain_vld", 32'(vld), 32'd0);
   endtask

   task automatic run_frames(input int m, input int n);
      int base;
      md   = 2'(m);
      base = sof_cnt;
      push_frames(m, n);
      en = 1'b1;
      wait_sofs(base + n);
      en = 1'b0;
      wait_drain();
      chk("fcnt", 32'(fcnt), 32'(fexp));
   endtask

   // Ready changes just after the active edge so the monitor sees it settled.
   initial begin
      rdy = 1'b1;
      forever begin
         @(posedge clk); #1;
         rdy = rnd ? 1'($urandom_range(0, 1)) : rdy_fix;
      end
   end

   initial begin
      logic        hold_v;
      logic [25:0] hold_d, e;
      hold_v = 1'b0;
      hold_d = '0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            hold_v = 1'b0;
         end else begin
            if (hold_v) begin
               chk("hold_vld", 32'(vld), 32'd1);
               chk("hold_dat", 32'({sof, eof, dat}), 32'(hold_d));
            end
            hold_v = vld && !rdy;
            hold_d = {sof, eof, dat};
            if (vld && rdy) begin
               if (exp_q.size() == 0) begin
                  chk("extra_pix", 32'd1, 32'd0);
               end else begin
                  e = exp_q.pop_front();
                  chk("pix", 32'({sof, eof, dat}), 32'(e));
               end
               if (sof) begin
                  mx = 0; my = 0; sof_cnt++;
               end
               if (my < V && mx < H) cap[my][mx] = dat;
               if (mx == 10 && my == 5) p105.push_back(dat);
               xfer_cnt++;
               mx++;
               if (mx == H) begin
                  mx = 0; my++;
               end
            end
         end
      end
   end

   initial begin
      int e = 0;
      int t = 0;
      rst_b_n = 1'b0; en_b = 1'b0; md_b = 2'd3; rdy_b = 1'b1;
      repeat (2) @(negedge clk);
      rst_b_n = 1'b1;
      en_b    = 1'b1;
      while (e < 256 && t < 8000) begin
         @(negedge clk);
         t++;
         if (vld_b && eof_b) begin
            e++;
            if (e == 1)   chk("b_f0_last", 32'(dat_b), 32'h070000);
            if (e == 255) chk("b_fcnt255", 32'(fcnt_b), 32'd255);
            if (e == 256) begin
               chk("b_wrap", 32'(fcnt_b), 32'd0);
               chk("b_f255_last", 32'(dat_b), 32'h0600FF);
            end
         end
      end
      chk("b_frames", 32'(e), 32'd256);
      en_b   = 1'b0;
      b_done = 1'b1;
   end

   initial begin
      int base, t;
      rst_n = 1'b0; en = 1'b0; md = 2'd0; fexp = '0;
      repeat (3) @(negedge clk);
      chk("rst_vld", 32'(vld), 32'd0);
      chk("rst_dat", 32'(dat), 32'd0);
      chk("rst_sof", 32'(sof), 32'd0);
      chk("rst_eof", 32'(eof), 32'd0);
      chk("rst_fcnt", 32'(fcnt), 32'd0);
      @(posedge clk); #2 rst_n = 1'b1;

      base = xfer_cnt;
      run_frames(0, 1);
      chk("m0_count", 32'(xfer_cnt - base), 32'(H * V));
      chk("m0_x0", 32'(cap[0][0]), 32'hFFFFFF);
      chk("m0_x8", 32'(cap[0][8]), 32'hFFFF00);
      chk("m0_x56", 32'(cap[0][56]), 32'h000000);

      rnd = 1'b1;
      run_frames(1, 1);
      rnd = 1'b0;
      chk("m1_x44", 32'(cap[0][44]), 32'h2C2C2C);

      run_frames(2, 1);
      chk("m2_31_0", 32'(cap[0][31]), 32'hFFFFFF);
      chk("m2_32_0", 32'(cap[0][32]), 32'h000000);
      chk("m2_32_32", 32'(cap[32][32]), 32'hFFFFFF);

      // Mode/enable change mid-frame must not take effect until the frame completes.
      md = 2'd0;
      base = sof_cnt;
      push_frames(0, 1);
      en = 1'b1;
      t = 0;
      while (!(sof_cnt > base && my == 20) && t < 30000) begin
         @(negedge clk); #1; t++;
      end
      chk("line20_wait", 32'(my), 32'd20);
      md = 2'd2;
      en = 1'b0;
      wait_drain();
      chk("chg_fcnt", 32'(fcnt), 32'(fexp));
      repeat (5) @(negedge clk);
      chk("idle_vld", 32'(vld), 32'd0);
      run_frames(2, 1);

      // Reset while stalled mid-line.
      md = 2'd1;
      base = xfer_cnt;
      push_frames(1, 1);
      en = 1'b1;
      t = 0;
      while (xfer_cnt < base + 100 && t < 30000) begin
         @(negedge clk); #1; t++;
      end
      rdy_fix = 1'b0;
      repeat (3) @(negedge clk);
      #1 chk("bp_vld", 32'(vld), 32'd1);
      @(posedge clk); #2 rst_n = 1'b0;
      #1;
      chk("arst_vld", 32'(vld), 32'd0);
      chk("arst_dat", 32'(dat), 32'd0);
      chk("arst_sof", 32'(sof), 32'd0);
      chk("arst_fcnt", 32'(fcnt), 32'd0);
      exp_q.delete();
      p105.delete();
      fexp    = '0;
      rdy_fix = 1'b1;
      md      = 2'd3;
      base    = sof_cnt;
      push_frames(3, 3);
      repeat (2) @(negedge clk);
      @(posedge clk); #2 rst_n = 1'b1;
      @(posedge clk); #1 chk("lat_vld", 32'(vld), 32'd0);
      wait_sofs(base + 3);
      en = 1'b0;
      wait_drain();
      chk("m3_fcnt", 32'(fcnt), 32'd3);
      chk("m3_n105", 32'(p105.size()), 32'd3);
      if (p105.size() == 3) begin
         chk("m3_f0", 32'(p105[0]), 32'h0A0500);
         chk("m3_f1", 32'(p105[1]), 32'h0B0501);
         chk("m3_f2", 32'(p105[2]), 32'h0C0502);
      end

      t = 0;
      while (!b_done && t < 10000) begin
         @(negedge clk); t++;
      end
      chk("b_done", 32'(b_done), 32'd1);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
